// File: rtl/conv55_window_sequencer.sv
// conv55_window_sequencer: streaming 5x5 window/kernel sequencer for the 6-bit conv datapath
// Ports: start/load_kernel begin a frame; k_* loads 25 weights; pix_* accepts raster pixels;
// win_data/kern_data feed the datapath; conv_sum returns its sum; out_* delivers registered
// results with backpressure; busy = not idle; done pulses after the last result handshake.
module conv55_window_sequencer #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int DW    = 6,
  parameter int OW    = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             load_kernel,
  input  logic             k_valid,
  output logic             k_ready,
  input  logic [DW-1:0]    k_data,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [DW-1:0]    pix_data,
  output logic [25*DW-1:0] win_data,
  output logic [25*DW-1:0] kern_data,
  input  logic [OW-1:0]    conv_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OW-1:0]    out_data,
  output logic             busy,
  output logic             done
);
  localparam int NRES = (IMG_W - 4) * (IMG_H - 4);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int NW = $clog2(NRES + 1);
  localparam logic [1:0] IDLE = 2'd0, LOAD_K = 2'd1, STREAM = 2'd2, DONE = 2'd3;
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  localparam logic [NW-1:0] RES_MAX = NW'(NRES - 1);
  logic [1:0]                       state_q, state_d;
  logic [4:0]                       kcnt_q, kcnt_d;
  logic [CW-1:0]                    col_q, col_d;
  logic [RW-1:0]                    row_q, row_d;
  logic [NW-1:0]                    rcnt_q, rcnt_d;
  logic                             pend_q, pend_d;
  logic                             last_q, last_d;
  logic                             ov_q, ov_d;
  logic [OW-1:0]                    od_q, od_d;
  logic [24:0][DW-1:0]              win_q, win_d;
  logic [24:0][DW-1:0]              kern_q, kern_d;
  logic [3:0][IMG_W-1:0][DW-1:0]    lb_q, lb_d;
  logic [4:0][DW-1:0]               new_col;
  logic                             p_acc, o_acc;
  assign k_ready   = state_q == LOAD_K;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign win_data  = win_q;
  assign kern_data = kern_q;
  // last_q blocks any pixel beyond the frame while the final result drains
  assign pix_ready = (state_q == STREAM) && !pend_q && !last_q && (!ov_q || out_ready);
  assign p_acc     = pix_valid && pix_ready;
  assign o_acc     = ov_q && out_ready;
  // lb row 0 holds the oldest buffered row, so the column enters oldest-first
  assign new_col   = {pix_data, lb_q[3][col_q], lb_q[2][col_q], lb_q[1][col_q], lb_q[0][col_q]};
  always_comb begin
    state_d = state_q;
    kcnt_d  = kcnt_q;
    col_d   = col_q;
    row_d   = row_q;
    rcnt_d  = rcnt_q;
    pend_d  = pend_q;
    last_d  = last_q;
    od_d    = od_q;
    win_d   = win_q;
    kern_d  = kern_q;
    lb_d    = lb_q;
    ov_d    = pend_q ? 1'b1 : (o_acc ? 1'b0 : ov_q);
    case (state_q)
      IDLE: if (start) begin
        state_d = load_kernel ? LOAD_K : STREAM;
        kcnt_d  = '0;
        col_d   = '0;
        row_d   = '0;
        rcnt_d  = '0;
        pend_d  = 1'b0;
        last_d  = 1'b0;
      end
      LOAD_K: if (k_valid) begin
        kern_d[kcnt_q] = k_data;
        kcnt_d         = kcnt_q + 1'b1;
        state_d        = (kcnt_q == 5'd24) ? STREAM : LOAD_K;
      end
      STREAM: begin
        if (p_acc) begin
          lb_d[0][col_q] = lb_q[1][col_q];
          lb_d[1][col_q] = lb_q[2][col_q];
          lb_d[2][col_q] = lb_q[3][col_q];
          lb_d[3][col_q] = pix_data;
          for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) win_d[5*r+c] = win_q[5*r+c+1];
            win_d[5*r+4] = new_col[r];
          end
          col_d  = (col_q == COL_MAX) ? '0 : col_q + 1'b1;
          row_d  = (col_q == COL_MAX) ? row_q + 1'b1 : row_q;
          // windows straddling a row wrap are excluded by the col >= 4 test
          pend_d = (row_q >= RW'(4)) && (col_q >= CW'(4));
          last_d = (row_q == ROW_MAX) && (col_q == COL_MAX);
        end
        if (pend_q) begin
          od_d   = conv_sum;
          pend_d = 1'b0;
        end
        if (o_acc) begin
          rcnt_d  = rcnt_q + 1'b1;
          state_d = (rcnt_q == RES_MAX) ? DONE : STREAM;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      kcnt_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      rcnt_q  <= '0;
      pend_q  <= 1'b0;
      last_q  <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      win_q   <= '0;
      kern_q  <= '0;
      lb_q    <= '0;
    end else begin
      state_q <= state_d;
      kcnt_q  <= kcnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      rcnt_q  <= rcnt_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      win_q   <= win_d;
      kern_q  <= kern_d;
      lb_q    <= lb_d;
    end
  end
endmodule

// File: tb/tb_conv55_window_sequencer.sv
// tb_conv55_window_sequencer: directed frames against a golden 5x5 convolution of the image
module tb_conv55_window_sequencer;
  localparam int W = 28, H = 28, NPIX = W * H, NRES = (W - 4) * (H - 4);
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, load_kernel = 1'b0;
  logic k_valid = 1'b0, pix_valid = 1'b0, out_ready = 1'b0;
  logic k_ready, pix_ready, out_valid, busy, done;
  logic [5:0] k_data = '0, pix_data = '0;
  logic [149:0] win_data, kern_data;
  logic [17:0] conv_sum, out_data;
  logic [5:0] img [NPIX];
  logic [5:0] kw [25];
  logic [17:0] res_q [$];
  int done_cnt, stab_err, overrun, timeout, lat, vec_cnt = 0, err_cnt = 0;
  logic busy_after;
  conv55_window_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_kernel(load_kernel),
    .k_valid(k_valid), .k_ready(k_ready), .k_data(k_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .win_data(win_data), .kern_data(kern_data), .conv_sum(conv_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always_comb begin
    conv_sum = '0;
    for (int i = 0; i < 25; i++) conv_sum = conv_sum + 18'(win_data[6*i+:6]) * 18'(kern_data[6*i+:6]);
  end
  function automatic logic [17:0] model(input int n);
    logic [17:0] s = '0;
    int r = 4 + n / (W - 4), c = 4 + n % (W - 4);
    for (int wr = 0; wr < 5; wr++)
      for (int wc = 0; wc < 5; wc++)
        s = s + 18'(kw[5*wr+wc]) * 18'(img[(r-4+wr)*W + (c-4+wc)]);
    return s;
  endfunction
  task automatic run_frame(input bit ld, input int rdy_pct, input int val_pct, input int abort_at, input bit noise);
    int kidx = 0, pidx = 0, cyc = 0, t_acc = -1, t_ov = -1, post = -1;
    logic hold = 1'b0;
    logic [17:0] hold_d = '0;
    res_q.delete();
    done_cnt = 0; stab_err = 0; overrun = 0; timeout = 0; lat = -1; busy_after = 1'b1;
    @(negedge clk);
    start = 1'b1; load_kernel = ld;
    @(negedge clk);
    while (1) begin
      start       = noise && post < 0 && (cyc % 97 == 50);
      load_kernel = start;
      out_ready   = $urandom_range(99) < rdy_pct;
      k_valid     = (ld && kidx < 25) ? ($urandom_range(99) < val_pct) : 1'b1;
      k_data      = (ld && kidx < 25) ? kw[kidx] : 6'($urandom);
      pix_valid   = (pidx < NPIX) ? ($urandom_range(99) < val_pct) : 1'b1;
      pix_data    = (pidx < NPIX) ? img[pidx] : 6'($urandom);
      #1;
      if (hold && (!out_valid || out_data !== hold_d)) stab_err++;
      hold = out_valid && !out_ready;
      hold_d = out_data;
      if (out_valid && out_ready) res_q.push_back(out_data);
      if (out_valid && t_ov < 0) t_ov = cyc;
      if (k_valid && k_ready) kidx++;
      if (pix_valid && pix_ready) begin
        if (pidx >= NPIX) overrun++;
        else if (t_acc < 0 && pidx / W >= 4 && pidx % W >= 4) t_acc = cyc;
        pidx++;
      end
      if (post >= 0) post++;
      if (post == 1) busy_after = busy;
      if (done) begin
        done_cnt++;
        if (post < 0) post = 0;
      end
      if (post == 4) break;
      if (abort_at > 0 && pidx >= abort_at) break;
      if (cyc >= 20000) begin
        timeout = 1;
        break;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0; load_kernel = 1'b0; k_valid = 1'b0; pix_valid = 1'b0; out_ready = 1'b0;
    lat = (t_acc >= 0 && t_ov >= 0) ? t_ov - t_acc : -1;
  endtask
  task automatic test_reset;
    #12;
    vec_cnt += 8;
    if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (done !== 1'b0) begin err_cnt++; $display("FAIL rst_done: got %b expected 0", done); end
    if (k_ready !== 1'b0) begin err_cnt++; $display("FAIL rst_k_ready: got %b expected 0", k_ready); end
    if (pix_ready !== 1'b0) begin err_cnt++; $display("FAIL rst_pix_ready: got %b expected 0", pix_ready); end
    if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    if (out_data !== 18'd0) begin err_cnt++; $display("FAIL rst_out_data: got %0d expected 0", out_data); end
    if (win_data !== 150'd0) begin err_cnt++; $display("FAIL rst_win_data: got %h expected 0", win_data); end
    if (kern_data !== 150'd0) begin err_cnt++; $display("FAIL rst_kern_data: got %h expected 0", kern_data); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_all_ones;
    for (int i = 0; i < 25; i++) kw[i] = 6'd1;
    for (int i = 0; i < NPIX; i++) img[i] = 6'd1;
    run_frame(1'b1, 100, 100, 0, 1'b0);
    vec_cnt += 6;
    if (timeout !== 0) begin err_cnt++; $display("FAIL ones_timeout: got %0d expected 0", timeout); end
    if (res_q.size() !== NRES) begin err_cnt++; $display("FAIL ones_count: got %0d expected %0d", res_q.size(), NRES); end
    if (done_cnt !== 1) begin err_cnt++; $display("FAIL ones_done: got %0d expected 1", done_cnt); end
    if (busy_after !== 1'b0) begin err_cnt++; $display("FAIL ones_busy_after: got %b expected 0", busy_after); end
    if (lat !== 2) begin err_cnt++; $display("FAIL ones_latency: got %0d expected 2", lat); end
    if (overrun !== 0) begin err_cnt++; $display("FAIL ones_overrun: got %0d expected 0", overrun); end
    for (int i = 0; i < NRES; i++) begin
      logic [17:0] got = i < res_q.size() ? res_q[i] : 'x;
      vec_cnt++;
      if (got !== 18'd25) begin err_cnt++; $display("FAIL ones_res[%0d]: got %0d expected 25", i, got); end
    end
  endtask
  task automatic test_newest;
    for (int i = 0; i < 25; i++) kw[i] = (i == 24) ? 6'd1 : 6'd0;
    for (int i = 0; i < NPIX; i++) img[i] = 6'(i % 64);
    run_frame(1'b1, 100, 100, 0, 1'b0);
    vec_cnt += 2;
    if (res_q.size() !== NRES) begin err_cnt++; $display("FAIL newest_count: got %0d expected %0d", res_q.size(), NRES); end
    if (res_q.size() == 0 || res_q[0] !== 18'd52) begin err_cnt++; $display("FAIL newest_first: got %0d expected 52", res_q.size() ? res_q[0] : 18'd0); end
    for (int i = 0; i < NRES; i++) begin
      logic [17:0] got = i < res_q.size() ? res_q[i] : 'x;
      logic [17:0] exp = 18'(img[(4 + i / (W - 4)) * W + 4 + i % (W - 4)]);
      vec_cnt++;
      if (got !== exp) begin err_cnt++; $display("FAIL newest_res[%0d]: got %0d expected %0d", i, got, exp); end
    end
  endtask
  task automatic test_corner;
    for (int i = 0; i < 25; i++) kw[i] = (i == 0) ? 6'd63 : 6'd0;
    for (int i = 0; i < NPIX; i++) img[i] = 6'd63;
    run_frame(1'b1, 100, 100, 0, 1'b0);
    vec_cnt++;
    if (res_q.size() !== NRES) begin err_cnt++; $display("FAIL corner_count: got %0d expected %0d", res_q.size(), NRES); end
    for (int i = 0; i < NRES; i++) begin
      logic [17:0] got = i < res_q.size() ? res_q[i] : 'x;
      vec_cnt++;
      if (got !== 18'd3969) begin err_cnt++; $display("FAIL corner_res[%0d]: got %0d expected 3969", i, got); end
    end
  endtask
  task automatic test_backpressure;
    for (int i = 0; i < 25; i++) kw[i] = 6'($urandom_range(63, 1));
    for (int i = 0; i < NPIX; i++) img[i] = 6'($urandom_range(63));
    run_frame(1'b1, 30, 70, 0, 1'b0);
    vec_cnt += 4;
    if (timeout !== 0) begin err_cnt++; $display("FAIL bp_timeout: got %0d expected 0", timeout); end
    if (stab_err !== 0) begin err_cnt++; $display("FAIL bp_stable: got %0d unstable holds expected 0", stab_err); end
    if (res_q.size() !== NRES) begin err_cnt++; $display("FAIL bp_count: got %0d expected %0d", res_q.size(), NRES); end
    if (done_cnt !== 1) begin err_cnt++; $display("FAIL bp_done: got %0d expected 1", done_cnt); end
    for (int i = 0; i < NRES; i++) begin
      logic [17:0] got = i < res_q.size() ? res_q[i] : 'x;
      vec_cnt++;
      if (got !== model(i)) begin err_cnt++; $display("FAIL bp_res[%0d]: got %0d expected %0d", i, got, model(i)); end
    end
  endtask
  task automatic test_reuse;
    for (int i = 0; i < NPIX; i++) img[i] = 6'($urandom_range(63));
    run_frame(1'b0, 60, 90, 0, 1'b1);
    vec_cnt += 3;
    if (res_q.size() !== NRES) begin err_cnt++; $display("FAIL reuse_count: got %0d expected %0d", res_q.size(), NRES); end
    if (done_cnt !== 1) begin err_cnt++; $display("FAIL reuse_done: got %0d expected 1", done_cnt); end
    if (busy_after !== 1'b0) begin err_cnt++; $display("FAIL reuse_busy_after: got %b expected 0", busy_after); end
    for (int i = 0; i < NRES; i++) begin
      logic [17:0] got = i < res_q.size() ? res_q[i] : 'x;
      vec_cnt++;
      if (got !== model(i)) begin err_cnt++; $display("FAIL reuse_res[%0d]: got %0d expected %0d", i, got, model(i)); end
    end
  endtask
  task automatic test_abort;
    for (int i = 0; i < 25; i++) kw[i] = 6'($urandom_range(63, 1));
    for (int i = 0; i < NPIX; i++) img[i] = 6'($urandom_range(63, 1));
    run_frame(1'b1, 100, 100, 300, 1'b0);
    vec_cnt++;
    if (busy !== 1'b1) begin err_cnt++; $display("FAIL abort_busy_before: got %b expected 1", busy); end
    rst_n = 1'b0;
    #1;
    vec_cnt += 6;
    if (busy !== 1'b0) begin err_cnt++; $display("FAIL abort_busy: got %b expected 0", busy); end
    if (pix_ready !== 1'b0) begin err_cnt++; $display("FAIL abort_pix_ready: got %b expected 0", pix_ready); end
    if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL abort_out_valid: got %b expected 0", out_valid); end
    if (out_data !== 18'd0) begin err_cnt++; $display("FAIL abort_out_data: got %0d expected 0", out_data); end
    if (win_data !== 150'd0) begin err_cnt++; $display("FAIL abort_win_data: got %h expected 0", win_data); end
    if (kern_data !== 150'd0) begin err_cnt++; $display("FAIL abort_kern_data: got %h expected 0", kern_data); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) kw[i] = 6'($urandom_range(63));
    for (int i = 0; i < NPIX; i++) img[i] = 6'($urandom_range(63));
    run_frame(1'b1, 100, 100, 0, 1'b0);
    vec_cnt += 2;
    if (res_q.size() !== NRES) begin err_cnt++; $display("FAIL clean_count: got %0d expected %0d", res_q.size(), NRES); end
    if (done_cnt !== 1) begin err_cnt++; $display("FAIL clean_done: got %0d expected 1", done_cnt); end
    for (int i = 0; i < NRES; i++) begin
      logic [17:0] got = i < res_q.size() ? res_q[i] : 'x;
      vec_cnt++;
      if (got !== model(i)) begin err_cnt++; $display("FAIL clean_res[%0d]: got %0d expected %0d", i, got, model(i)); end
    end
  endtask
  initial begin
    test_reset;
    test_all_ones;
    test_newest;
    test_corner;
    test_backpressure;
    test_reuse;
    test_abort;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
